// File: rtl/bp_pkg.sv
// Shared types and helpers for the BHT branch predictor: counter encodings,
// table entry layout and PC-to-index/tag extraction.
package bp_pkg;

    localparam int MAX_TAG_W = 28;
    localparam int MAX_CTR_W = 4;

    // Entry fields are sized for the widest legal configuration; narrower
    // builds write only the low bits, so the upper bits stay constant zero.
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [MAX_CTR_W-1:0] ctr;
        logic [31:0]          target;
    } bp_entry_t;

    function automatic logic [MAX_CTR_W-1:0] wnt(input int ctr_w);
        return MAX_CTR_W'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [MAX_CTR_W-1:0] wt(input int ctr_w);
        return MAX_CTR_W'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [MAX_CTR_W-1:0] sat_inc(input logic [MAX_CTR_W-1:0] ctr,
                                                     input int ctr_w);
        logic [MAX_CTR_W-1:0] top;
        top = MAX_CTR_W'((1 << ctr_w) - 1);
        return (ctr >= top) ? ctr : ctr + MAX_CTR_W'(1);
    endfunction

    function automatic logic [MAX_CTR_W-1:0] sat_dec(input logic [MAX_CTR_W-1:0] ctr);
        return (ctr == '0) ? ctr : ctr - MAX_CTR_W'(1);
    endfunction

    // Word-aligned PC: bits [1:0] never reach the index or tag.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [MAX_TAG_W-1:0] pc_tag(input logic [31:0] pc,
                                                    input int idx_w,
                                                    input int tag_w);
        logic [31:0] t;
        t = (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
        return MAX_TAG_W'(t);
    endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Saturating event counter with synchronous reset and count enable.
module bp_stat_counter #(
    parameter int STAT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    output logic [STAT_W-1:0] o_count
);

    logic [STAT_W-1:0] r_count;

    // Count enabled events, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + STAT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bht_branch_predictor.sv
// Direct-mapped tagged branch history table with saturating direction
// counters and stored targets, plus branch/mispredict statistics.
// Optional macro BHT_UPDATE_BYPASS_EN: forward a same-index update into the
// lookup result in the same cycle.
module bht_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       lookup_pc,
    output logic              predict_hit,
    output logic              predict_taken,
    output logic [31:0]       predict_target,
    input  logic              update_valid,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              update_mispredict,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t r_table [ENTRIES];

    logic [IDX_W-1:0]     w_lk_idx;
    logic [IDX_W-1:0]     w_up_idx;
    logic [MAX_TAG_W-1:0] w_lk_tag;
    logic [MAX_TAG_W-1:0] w_up_tag;
    logic                 w_up_hit;
    logic                 w_lk_hit;
    bp_entry_t            w_up_old;
    bp_entry_t            w_up_new;
    bp_entry_t            w_lk_entry;

    assign w_lk_idx = IDX_W'(pc_index(lookup_pc, IDX_W));
    assign w_up_idx = IDX_W'(pc_index(update_pc, IDX_W));
    assign w_lk_tag = pc_tag(lookup_pc, IDX_W, TAG_W);
    assign w_up_tag = pc_tag(update_pc, IDX_W, TAG_W);

    assign w_up_old = r_table[w_up_idx];
    assign w_up_hit = w_up_old.valid && (w_up_old.tag == w_up_tag);

    // Compute the entry as it will look after this cycle's update.
    always_comb begin
        w_up_new = w_up_old;
        if (w_up_hit) begin
            if (update_taken) begin
                w_up_new.ctr    = sat_inc(w_up_old.ctr, CTR_W);
                w_up_new.target = update_target;
            end else begin
                w_up_new.ctr    = sat_dec(w_up_old.ctr);
            end
        end else begin
            w_up_new.valid  = 1'b1;
            w_up_new.tag    = w_up_tag;
            w_up_new.target = update_target;
            w_up_new.ctr    = update_taken ? wt(CTR_W) : wnt(CTR_W);
        end
    end

    // Table storage: reset clears every entry, otherwise write the resolved branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid  <= 1'b0;
                r_table[i].tag    <= '0;
                r_table[i].ctr    <= wnt(CTR_W);
                r_table[i].target <= 32'd0;
            end
        end else if (update_valid) begin
            r_table[w_up_idx] <= w_up_new;
        end
    end

    // Select the entry seen by fetch, optionally forwarding a same-index update.
    always_comb begin
        w_lk_entry = r_table[w_lk_idx];
`ifdef BHT_UPDATE_BYPASS_EN
        if (update_valid && (w_up_idx == w_lk_idx)) begin
            w_lk_entry = w_up_new;
        end
`endif
    end

    // Reset masks the prediction so fetch never acts on pre-reset contents.
    assign w_lk_hit       = !reset && w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
    assign predict_hit    = w_lk_hit;
    assign predict_taken  = w_lk_hit && w_lk_entry.ctr[CTR_W-1];
    assign predict_target = w_lk_hit ? w_lk_entry.target : 32'd0;

    bp_stat_counter #(.STAT_W(STAT_W)) u_branch_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (update_valid),
        .o_count (branch_count)
    );

    bp_stat_counter #(.STAT_W(STAT_W)) u_mispredict_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (update_valid && update_mispredict),
        .o_count (mispredict_count)
    );

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Testbench for bht_branch_predictor (ENTRIES=64, CTR_W=2, TAG_W=8, STAT_W=32):
// directed scenarios followed by random traffic against a table model.
module tb_bht_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        predict_hit;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    bit          m_valid [64];
    int          m_tag   [64];
    int          m_ctr   [64];
    logic [31:0] m_tgt   [64];
    longint      m_bc;
    longint      m_mc;

    localparam longint STAT_MAX = 64'hFFFF_FFFF;

    bht_branch_predictor #(
        .ENTRIES (64),
        .CTR_W   (2),
        .TAG_W   (8),
        .STAT_W  (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_pc         (lookup_pc),
        .predict_hit       (predict_hit),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / 256) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural rule for one resolved branch applied to one table slot.
    task automatic apply_rule(inout bit v, inout int tg, inout int ct, inout logic [31:0] tt,
                              input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        if (v && tg == tag_of(pc)) begin
            if (taken) begin
                ct = (ct + 1 > 3) ? 3 : ct + 1;
                tt = tgt;
            end else begin
                ct = (ct - 1 < 0) ? 0 : ct - 1;
            end
        end else begin
            v  = 1'b1;
            tg = tag_of(pc);
            tt = tgt;
            ct = taken ? 2 : 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 32'd0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit taken,
                                input logic [31:0] tgt, input bit misp);
        int          i;
        bit          v;
        int          tg;
        int          ct;
        logic [31:0] tt;
        i  = idx_of(pc);
        v  = m_valid[i];
        tg = m_tag[i];
        ct = m_ctr[i];
        tt = m_tgt[i];
        apply_rule(v, tg, ct, tt, pc, taken, tgt);
        m_valid[i] = v;
        m_tag[i]   = tg;
        m_ctr[i]   = ct;
        m_tgt[i]   = tt;
        if (m_bc < STAT_MAX) m_bc++;
        if (misp && m_mc < STAT_MAX) m_mc++;
    endtask

    // Compare every output against the model for the inputs currently driven.
    task automatic check_outputs();
        int          i;
        bit          v;
        int          tg;
        int          ct;
        logic [31:0] tt;
        bit          e_hit;
        i  = idx_of(lookup_pc);
        v  = m_valid[i];
        tg = m_tag[i];
        ct = m_ctr[i];
        tt = m_tgt[i];
`ifdef BHT_UPDATE_BYPASS_EN
        if (update_valid && idx_of(update_pc) == i)
            apply_rule(v, tg, ct, tt, update_pc, update_taken, update_target);
`endif
        e_hit = !reset && v && (tg == tag_of(lookup_pc));
        chk("cyc_hit",    {31'd0, predict_hit},   {31'd0, e_hit});
        chk("cyc_taken",  {31'd0, predict_taken}, {31'd0, e_hit && ct >= 2});
        chk("cyc_target", predict_target,         e_hit ? tt : 32'd0);
        chk("cyc_bcount", branch_count,           32'(m_bc));
        chk("cyc_mcount", mispredict_count,       32'(m_mc));
    endtask

    task automatic cyc(input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utg, input bit um, input bit rst);
        lookup_pc         = lk;
        update_valid      = uv;
        update_pc         = upc;
        update_taken      = ut;
        update_target     = utg;
        update_mispredict = um;
        reset             = rst;
        #1;
        check_outputs();
        @(posedge clk);
        if (rst) model_reset();
        else if (uv) model_update(upc, ut, utg, um);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                       input bit misp);
        cyc(32'h0, 1'b1, pc, taken, tgt, misp, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        reset        = 1'b0;
        update_valid = 1'b0;
        lookup_pc    = pc;
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rlk;
        model_reset();
        reset = 1'b1; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; update_mispredict = 1'b0;
        @(posedge clk); #1;
        cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // After reset: no prediction, counters cleared.
        look(32'h40);
        chk("rst_hit",    {31'd0, predict_hit},   32'd0);
        chk("rst_taken",  {31'd0, predict_taken}, 32'd0);
        chk("rst_target", predict_target,         32'd0);
        chk("rst_bcount", branch_count,           32'd0);
        chk("rst_mcount", mispredict_count,       32'd0);

        // First allocation as weakly taken.
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        chk("alloc_hit",    {31'd0, predict_hit},   32'd1);
        chk("alloc_taken",  {31'd0, predict_taken}, 32'd1);
        chk("alloc_target", predict_target,         32'h100);
        chk("alloc_bcount", branch_count,           32'd1);

        // Saturate high, one step down stays taken.
        repeat (4) upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        chk("sat_hi_taken", {31'd0, predict_taken}, 32'd1);
        repeat (3) upd(32'h40, 1'b0, 32'hDEAD, 1'b0);
        look(32'h40);
        chk("sat_lo_taken",  {31'd0, predict_taken}, 32'd0);
        chk("sat_lo_target", predict_target,         32'h100);
        chk("sat_lo_hit",    {31'd0, predict_hit},   32'd1);
        chk("sat_bcount",    branch_count,           32'd9);

        // Alias at index 0x10 replaces the entry with tag 0x40, weakly not-taken.
        upd(32'h4040, 1'b0, 32'h300, 1'b0);
        look(32'h40);
        chk("alias_old_hit", {31'd0, predict_hit}, 32'd0);
        look(32'h4040);
        chk("alias_new_hit",   {31'd0, predict_hit},   32'd1);
        chk("alias_new_taken", {31'd0, predict_taken}, 32'd0);
        upd(32'h4040, 1'b1, 32'h304, 1'b0);
        look(32'h4040);
        chk("alias_ctr_step",  {31'd0, predict_taken}, 32'd1);
        chk("alias_target",    predict_target,         32'h304);

        // Same-cycle lookup and update on a fresh index.
        lookup_pc = 32'h80; update_valid = 1'b1; update_pc = 32'h80;
        update_taken = 1'b1; update_target = 32'h200; update_mispredict = 1'b0;
        reset = 1'b0;
        #1;
`ifdef BHT_UPDATE_BYPASS_EN
        chk("same_cyc_hit",    {31'd0, predict_hit}, 32'd1);
        chk("same_cyc_target", predict_target,       32'h200);
`else
        chk("same_cyc_hit",    {31'd0, predict_hit}, 32'd0);
        chk("same_cyc_target", predict_target,       32'd0);
`endif
        @(posedge clk);
        model_update(32'h80, 1'b1, 32'h200, 1'b0);
        #1;
        look(32'h80);
        chk("post_same_hit", {31'd0, predict_hit}, 32'd1);

        // Mispredict counting, then reset swallowing a concurrent update.
        upd(32'hC0, 1'b1, 32'h400, 1'b1);
        upd(32'hC4, 1'b0, 32'h404, 1'b1);
        upd(32'hC8, 1'b1, 32'h408, 1'b1);
        look(32'hC0);
        chk("misp_mcount", mispredict_count, 32'd3);
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h500, 1'b1, 1'b1);
        look(32'h100);
        chk("rstupd_hit",    {31'd0, predict_hit}, 32'd0);
        chk("rstupd_mcount", mispredict_count,     32'd0);
        chk("rstupd_bcount", branch_count,         32'd0);
        look(32'hC0);
        chk("rstupd_old_hit", {31'd0, predict_hit}, 32'd0);

        // Random traffic over a small PC pool to exercise hits, aliases and resets.
        for (int n = 0; n < 600; n++) begin
            rpc = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                rlk = rpc;
            else
                rlk = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            cyc(rlk, 1'($urandom_range(0, 3) != 0), rpc, 1'($urandom_range(0, 1)),
                $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bht_branch_predictor.md
Name: bht_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined RISC-V core. Replaces the fixed single-bit `predict` path in InFetch.
- Direct-mapped table of tagged entries. Each entry holds a saturating counter and a branch target.
- Fetch performs a same-cycle lookup on the current PC. The Memory stage, which resolves branches, writes updates back.
- Carries saturating performance counters so the LED/FND debug path can display branch and mispredict totals.

Parameters:
- ENTRIES, 64: table depth; power of two, 4..1024. IDX_W = log2(ENTRIES).
- CTR_W, 2: saturating counter width, 1..4.
- TAG_W, 8: tag bits stored per entry, 1..(30-IDX_W).
- STAT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- lookup_pc  in  32  PC of the instruction being fetched
- predict_hit  out  1  entry valid and tag matches
- predict_taken  out  1  hit and counter MSB = 1
- predict_target  out  32  stored target; 0 when no hit
- update_valid  in  1  resolved branch/jal/jalr this cycle
- update_pc  in  32  PC of the resolved instruction
- update_taken  in  1  actual direction
- update_target  in  32  actual target (PCimm)
- update_mispredict  in  1  resolved outcome differed from the prediction used
- branch_count  out  STAT_W  number of accepted updates
- mispredict_count  out  STAT_W  number of accepted updates with update_mispredict = 1

Behaviour:
- Addressing:
  - index = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] is ignored.
- Lookup is combinational from table state. predict_* depend only on lookup_pc and the current registered table.
- Update is registered; it takes effect at the clk edge where update_valid = 1.
- Update, hit (entry valid, tag equal):
  - update_taken = 1: counter saturating +1; target is overwritten with update_target.
  - update_taken = 0: counter saturating -1; target is unchanged.
- Update, miss (entry invalid or tag differs): allocate/replace the entry.
  - valid = 1; tag written.
  - target = update_target.
  - counter = WT (weakly taken) if update_taken, else WNT (weakly not-taken).
- Counter encodings:
  - WNT = 2^(CTR_W-1) - 1
  - WT = 2^(CTR_W-1)
  - For CTR_W = 1: WNT = 0, WT = 1.
- Saturation: the counter holds at 0 and at 2^CTR_W - 1, with no wrap.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents (no bypass) unless the optional feature is enabled.
- Stat counters:
  - branch_count increments on every accepted update.
  - mispredict_count increments on every accepted update with update_mispredict = 1.
  - Both saturate at all-ones.
- Reset (synchronous, reset = 1 at clk edge):
  - All valid bits are cleared; all counters are set to WNT; all targets are set to 0.
  - branch_count = 0 and mispredict_count = 0.
  - Outputs after reset: predict_hit = 0, predict_taken = 0, predict_target = 0.
  - An update presented in the same cycle as reset is discarded, including partway through a run.
- Storage: no state machine. State is the table plus two counters; storage is flops, so the reset loop is required.

Optional Feature:
- Macro: BHT_UPDATE_BYPASS_EN.
- When defined: if update_valid = 1 and index(update_pc) = index(lookup_pc), the predict_* outputs reflect the post-update entry value in the same cycle.
- When undefined: the pre-update value is returned, as above.
- Reset still forces all predict outputs to 0 in the reset cycle, with or without the macro.

Decomposition:
- Package bp_pkg holds:
  - the counter encoding functions (wnt(CTR_W), wt(CTR_W), sat_inc, sat_dec);
  - the entry struct {valid, tag, ctr, target};
  - the index/tag extraction functions parameterised by IDX_W and TAG_W.
- Sub-module bp_stat_counter: parametrised STAT_W saturating counter with synchronous reset and enable. Instantiated twice, once per stat counter.

Test Plan (ENTRIES = 64, CTR_W = 2, TAG_W = 8):
- Reset, then lookup_pc = 0x40 -> predict_hit = 0, predict_taken = 0, predict_target = 0, both counts = 0.
- update pc = 0x40, taken = 1, target = 0x100 -> next cycle lookup 0x40 gives hit = 1, taken = 1, target = 0x100, branch_count = 1.
- Saturation: four taken updates on 0x40 then one not-taken -> still taken (counter 3→2). Three more not-taken -> counter 0, taken = 0, target = 0x100 unchanged.
- Alias: pc 0x40 allocated, then update pc = 0x4040 (same index 0x10, tag 0x40), taken = 0 -> lookup 0x40 misses. Lookup 0x4040 gives hit = 1, taken = 0, counter = 1.
- Same-cycle lookup and update on 0x80 (taken, target 0x200) -> hit = 0 without the macro; hit = 1, target = 0x200 with BHT_UPDATE_BYPASS_EN.
- update_mispredict = 1 for 3 updates, with reset asserted during a 4th -> mispredict_count = 3, then 0 after reset. The 4th update has no effect on the table.
